trigger_command_unit: RTL and testbench
=======================================

Name: trigger_command_unit

Overview:
Parametrised successor to the fixed trigger/command logic that drives the pixel sequencer. It decodes 16-bit SPI command words (CCCC + 12-bit data) into sequencer configuration registers, with an unlock gate on those writes. It synchronises the external trigger and, after a programmable delay, issues a one-cycle run_sequencer pulse followed by a programmable holdoff; the old fixed delay of 36 and holdoff of 99 become the reset defaults. It counts accepted and missed triggers and returns status over spi_d. It sits between spi16 and the sequencer.

Parameters:
TIME_W, 10, width of all time registers and the delay/holdoff counters
SEL_W, 4, width of the sel output
SYNC_STAGES, 2, trigger synchroniser depth (minimum 2)
TRIG_ACTIVE_LOW, 1, 1 means the trigger is active when trig_in is low
CNT_W, 16, width of the trigger and missed counters (CNT_W ≤ 16)

Ports:
clk  in  1  system clock (PLL c0)
res_n  in  1  asynchronous active-low reset
spi_write  in  1  one-cycle strobe; spi_q is valid
spi_q  in  16  command word [15:12]=code, [11:0]=data
spi_d  out  16  registered readback word
trig_in  in  1  asynchronous pulse-generator trigger
seq_ready  in  1  sequencer ready_flag
run_sequencer  out  1  one-cycle start pulse
busy  out  1  high in any state except IDLE
sel  out  SEL_W  configured SEL
block_reset, block_hold, polarity  out  1 each  configured flags
reset_release_time, aout_reset_release_time, measure_time  out  TIME_W each  sequencer timings
trig_count, missed_count  out  CNT_W each  saturating counters

Behaviour:
- Reset values: sel=0, all flags=0, all three timings=0, run_delay=36, holdoff=99, armed=1, spi_enable=0, read_sel=0, counters=0, run_sequencer=0, spi_d=0, state=IDLE.
- Command codes: 0 SEL, 1 BLOCK_RESET, 2 BLOCK_HOLD, 3 POLARITY, 4 RESET_RELEASE, 5 AOUT_RESET_RELEASE, 6 MEASURE_TIME, 7 RUN_DELAY, 8 HOLDOFF, 9 CMD_ENA, A TRIG_MODE, B READ_SEL, C CLEAR_COUNTERS. Codes D-F are ignored.
- Code 9 is always accepted and sets spi_enable<=data[0]. All other codes take effect only if spi_enable was 1 before the strobe. Data is truncated to the LSBs of the target register.
- TRIG_MODE: data[0] writes armed. data[2]=1 injects a one-cycle software trigger, equivalent to a sync edge and subject to the same arming and busy rules.
- Trigger path: trig_in passes through SYNC_STAGES flops and is polarity-normalised. edge = synced active and previous synced inactive, one cycle wide.
- FSM states:
  - IDLE: on trigger with armed=1, latch run_delay and holdoff, counter=0, go to DELAY.
  - DELAY: counter increments each cycle. When counter==latched delay, go to FIRE.
  - FIRE: if seq_ready=1, run_sequencer=1 for this cycle and trig_count++. Otherwise, no pulse and missed_count++. In both cases counter=0, go to HOLDOFF.
  - HOLDOFF: when counter==latched holdoff, go to IDLE; otherwise counter++.
- Latency: with edge in cycle E, run_sequencer is high in cycle E+run_delay+1. run_delay=0 gives the pulse at E+1. holdoff=0 returns to IDLE one cycle after FIRE.
- A trigger in DELAY, FIRE or HOLDOFF with armed=1 increments missed_count. The in-flight sequence is unaffected.
- Triggers with armed=0 are ignored and not counted. Disarming mid-sequence lets the current sequence complete.
- Config writes during a sequence do not change the latched delay/holdoff. Sequencer-facing registers update immediately.
- Counters saturate at all-ones. If CLEAR coincides with an increment, CLEAR wins (result 0).
- READ_SEL selects the value registered into spi_d every cycle: 0 = trig_count, 1 = missed_count, 2 = {state[1:0], armed, spi_enable} in bits [3:0], other values = 0.
- Asserting reset mid-sequence returns immediately to reset values with no run pulse.

Decomposition:
- Package trigger_command_pkg holds: command-code localparams, the FSM state encoding (IDLE/DELAY/FIRE/HOLDOFF), READ_SEL codes, and reset defaults 36/99.
- Sub-module trigger_sync_edge (parameters SYNC_STAGES, TRIG_ACTIVE_LOW; ports clk, res_n, async_in, edge).

Test Plan:
- After reset, pulse trig_in low for 3 cycles → exactly one run_sequencer pulse, 37 cycles after the edge flag; busy stays high 100 further cycles; trig_count=1.
- Write 0x0005 with spi_enable=0 → sel stays 0. Then write 0x9001, then 0x0005 → sel=5. Then write 0x9000, then 0x0003 → sel stays 5.
- With spi_enable=1, write 0x7000 and 0x8000, then trigger → pulse at E+1 and return to IDLE at E+3. Two triggers 10 cycles apart with default holdoff → missed_count=1.
- Hold seq_ready=0 and trigger → no run pulse, missed_count=1, trig_count=0.
- Write 0xA000 (disarm) and trigger → counters unchanged, busy=0. Write 0xA005 → software-trigger run pulse after the default delay.
- Preload missed_count to 0xFFFF and trigger again → stays 0xFFFF. Write 0xC000 in the same cycle as an increment → 0. Write 0xB001 → spi_d=missed_count within 1 cycle.

Source files
------------

// File: rtl/trigger_command_pkg.sv
// Shared command codes, FSM encoding, readback selectors and timing defaults for trigger_command_unit.
package trigger_command_pkg;

  localparam logic [3:0] CMD_SEL        = 4'h0;
  localparam logic [3:0] CMD_BLOCK_RST  = 4'h1;
  localparam logic [3:0] CMD_BLOCK_HOLD = 4'h2;
  localparam logic [3:0] CMD_POLARITY   = 4'h3;
  localparam logic [3:0] CMD_RST_REL    = 4'h4;
  localparam logic [3:0] CMD_AOUT_REL   = 4'h5;
  localparam logic [3:0] CMD_MEAS_TIME  = 4'h6;
  localparam logic [3:0] CMD_RUN_DELAY  = 4'h7;
  localparam logic [3:0] CMD_HOLDOFF    = 4'h8;
  localparam logic [3:0] CMD_ENA        = 4'h9;
  localparam logic [3:0] CMD_TRIG_MODE  = 4'hA;
  localparam logic [3:0] CMD_READ_SEL   = 4'hB;
  localparam logic [3:0] CMD_CLEAR      = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [1:0] RD_TRIG   = 2'd0;
  localparam logic [1:0] RD_MISSED = 2'd1;
  localparam logic [1:0] RD_STATUS = 2'd2;

  localparam int DEF_RUN_DELAY = 36;
  localparam int DEF_HOLDOFF   = 99;

endpackage

// File: rtl/trigger_sync_edge.sv
// Synchronises an asynchronous trigger and emits a one-cycle pulse on its activation.
// Latency: edge appears SYNC_STAGES cycles after the input changes. No backpressure.
module trigger_sync_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter bit TRIG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic res_n,
  input  logic async_in,
  output logic trig_edge
);

  // Reset to the inactive level so releasing reset never fakes a trigger.
  localparam logic IDLE_LVL = TRIG_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [SYNC_STAGES-1:0] sync;
  logic                   active;
  logic                   active_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync     <= {SYNC_STAGES{IDLE_LVL}};
      active_q <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], async_in};
      active_q <= active;
    end
  end

  assign active    = sync[SYNC_STAGES-1] ^ IDLE_LVL;
  assign trig_edge = active & ~active_q;

endmodule

// File: rtl/trigger_command_unit.sv
// SPI command decoder plus trigger -> delay -> run pulse -> holdoff sequencer with counters.
// Latency: run pulse E+run_delay+1 after trigger edge E. No backpressure; missed triggers are counted.
module trigger_command_unit
  import trigger_command_pkg::*;
#(
  parameter int TIME_W          = 10,
  parameter int SEL_W           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter bit TRIG_ACTIVE_LOW = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              spi_write,
  input  logic [15:0]       spi_q,
  output logic [15:0]       spi_d,
  input  logic              trig_in,
  input  logic              seq_ready,
  output logic              run_sequencer,
  output logic              busy,
  output logic [SEL_W-1:0]  sel,
  output logic              block_reset,
  output logic              block_hold,
  output logic              polarity,
  output logic [TIME_W-1:0] reset_release_time,
  output logic [TIME_W-1:0] aout_reset_release_time,
  output logic [TIME_W-1:0] measure_time,
  output logic [CNT_W-1:0]  trig_count,
  output logic [CNT_W-1:0]  missed_count
);

  localparam logic [TIME_W-1:0] T_ONE = 1;

  logic [3:0]        code;
  logic [11:0]       data;
  logic              cmd_ok;
  logic              trig_edge;
  logic              sw_trig;
  logic              trigger;
  logic              armed;
  logic              spi_enable;
  logic [1:0]        read_sel;
  logic [TIME_W-1:0] run_delay, holdoff;
  logic [TIME_W-1:0] dly_l, hold_l, cnt, cnt_inc;
  state_t            state;
  logic              trig_inc;
  logic [1:0]        miss_inc;

  assign code    = spi_q[15:12];
  assign data    = spi_q[11:0];
  assign cmd_ok  = spi_write & spi_enable;
  assign trigger = trig_edge | sw_trig;
  assign cnt_inc = cnt + T_ONE;
  assign busy    = (state != ST_IDLE);

  trigger_sync_edge #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TRIG_ACTIVE_LOW(TRIG_ACTIVE_LOW)
  ) u_sync (
    .clk      (clk),
    .res_n    (res_n),
    .async_in (trig_in),
    .trig_edge(trig_edge)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sel                     <= '0;
      block_reset             <= 1'b0;
      block_hold              <= 1'b0;
      polarity                <= 1'b0;
      reset_release_time      <= '0;
      aout_reset_release_time <= '0;
      measure_time            <= '0;
      run_delay               <= TIME_W'(DEF_RUN_DELAY);
      holdoff                 <= TIME_W'(DEF_HOLDOFF);
      armed                   <= 1'b1;
      spi_enable              <= 1'b0;
      read_sel                <= '0;
      sw_trig                 <= 1'b0;
    end else begin
      if (spi_write && code == CMD_ENA) spi_enable <= data[0];
      sw_trig <= cmd_ok && (code == CMD_TRIG_MODE) && data[2];
      if (cmd_ok) begin
        case (code)
          CMD_SEL:        sel                     <= SEL_W'(data);
          CMD_BLOCK_RST:  block_reset             <= data[0];
          CMD_BLOCK_HOLD: block_hold              <= data[0];
          CMD_POLARITY:   polarity                <= data[0];
          CMD_RST_REL:    reset_release_time      <= TIME_W'(data);
          CMD_AOUT_REL:   aout_reset_release_time <= TIME_W'(data);
          CMD_MEAS_TIME:  measure_time            <= TIME_W'(data);
          CMD_RUN_DELAY:  run_delay               <= TIME_W'(data);
          CMD_HOLDOFF:    holdoff                 <= TIME_W'(data);
          CMD_TRIG_MODE:  armed                   <= data[0];
          CMD_READ_SEL:   read_sel                <= 2'(data);
          default: ;
        endcase
      end
    end
  end

  // seq_ready is sampled on entry to FIRE so the pulse is a clean register output in the FIRE cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dly_l         <= '0;
      hold_l        <= '0;
      run_sequencer <= 1'b0;
    end else begin
      run_sequencer <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger && armed) begin
            dly_l  <= run_delay;
            hold_l <= holdoff;
            cnt    <= '0;
            if (run_delay == '0) begin
              state         <= ST_FIRE;
              run_sequencer <= seq_ready;
            end else begin
              state <= ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          cnt <= cnt_inc;
          if (cnt_inc == dly_l) begin
            state         <= ST_FIRE;
            run_sequencer <= seq_ready;
          end
        end
        ST_FIRE: begin
          cnt   <= '0;
          state <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (cnt == hold_l) state <= ST_IDLE;
          else               cnt   <= cnt_inc;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    trig_inc = 1'b0;
    miss_inc = 2'd0;
    if (state == ST_FIRE) begin
      if (run_sequencer) trig_inc = 1'b1;
      else               miss_inc = 2'd1;
    end
    if (trigger && armed && state != ST_IDLE) miss_inc = miss_inc + 2'd1;
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      trig_count   <= '0;
      missed_count <= '0;
    end else if (cmd_ok && code == CMD_CLEAR) begin
      trig_count   <= '0;
      missed_count <= '0;
    end else begin
      trig_count   <= sat_add(trig_count, {1'b0, trig_inc});
      missed_count <= sat_add(missed_count, miss_inc);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      spi_d <= '0;
    end else begin
      case (read_sel)
        RD_TRIG:   spi_d <= 16'(trig_count);
        RD_MISSED: spi_d <= 16'(missed_count);
        RD_STATUS: spi_d <= {12'd0, state, armed, spi_enable};
        default:   spi_d <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_command_unit.sv
// Randomised + directed bench for trigger_command_unit with a timeline-level reference model and pulse scoreboard.
module tb_trigger_command_unit;

  localparam int TIME_W      = 10;
  localparam int SEL_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              res_n = 1'b0;
  logic              spi_write = 1'b0;
  logic [15:0]       spi_q = '0;
  logic [15:0]       spi_d;
  logic              trig_in = 1'b1;
  logic              seq_ready = 1'b1;
  logic              run_sequencer, busy;
  logic [SEL_W-1:0]  sel;
  logic              block_reset, block_hold, polarity;
  logic [TIME_W-1:0] reset_release_time, aout_reset_release_time, measure_time;
  logic [CNT_W-1:0]  trig_count, missed_count;

  trigger_command_unit #(
    .TIME_W(TIME_W), .SEL_W(SEL_W), .SYNC_STAGES(SYNC_STAGES), .TRIG_ACTIVE_LOW(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .res_n(res_n), .spi_write(spi_write), .spi_q(spi_q), .spi_d(spi_d),
    .trig_in(trig_in), .seq_ready(seq_ready), .run_sequencer(run_sequencer), .busy(busy),
    .sel(sel), .block_reset(block_reset), .block_hold(block_hold), .polarity(polarity),
    .reset_release_time(reset_release_time), .aout_reset_release_time(aout_reset_release_time),
    .measure_time(measure_time), .trig_count(trig_count), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  // Reference model state
  int m_en, m_armed, m_dly, m_hold, m_sel, m_br, m_bh, m_pol, m_rr, m_arr, m_mt, m_rsel;
  int m_trig, m_miss, m_idle_at, m_sr;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_armed = 1; m_dly = 36; m_hold = 99; m_sel = 0; m_br = 0; m_bh = 0; m_pol = 0;
    m_rr = 0; m_arr = 0; m_mt = 0; m_rsel = 0; m_trig = 0; m_miss = 0; m_idle_at = 0;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Trigger seen by the unit in cycle e: start a sequence, count as missed, or ignore.
  task automatic model_trig(input int e);
    if (m_armed == 0) return;
    if (e < m_idle_at) begin
      m_miss = sat(m_miss + 1);
    end else begin
      if (m_sr != 0) begin
        exp_q.push_back(e + m_dly + 1);
        m_trig = sat(m_trig + 1);
      end else begin
        m_miss = sat(m_miss + 1);
      end
      m_idle_at = e + m_dly + 3 + m_hold;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wr(input logic [15:0] w);
    int c, d, swt;
    c = int'(w[15:12]);
    d = int'(w[11:0]);
    swt = 0;
    spi_write = 1'b1;
    spi_q = w;
    if (c == 9) m_en = d % 2;
    else if (m_en != 0) begin
      case (c)
        0: m_sel = d % (1 << SEL_W);
        1: m_br = d % 2;
        2: m_bh = d % 2;
        3: m_pol = d % 2;
        4: m_rr = d % (1 << TIME_W);
        5: m_arr = d % (1 << TIME_W);
        6: m_mt = d % (1 << TIME_W);
        7: m_dly = d % (1 << TIME_W);
        8: m_hold = d % (1 << TIME_W);
        10: begin m_armed = d % 2; swt = (d / 4) % 2; end
        11: m_rsel = d % 4;
        12: begin m_trig = 0; m_miss = 0; end
        default: ;
      endcase
    end
    tick();
    spi_write = 1'b0;
    if (swt != 0) model_trig(cyc);
  endtask

  task automatic trig(input int len);
    trig_in = 1'b0;
    model_trig(cyc + SYNC_STAGES);
    repeat (len) tick();
    trig_in = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_idle();
    to_cyc(m_idle_at);
    chk("busy_at_idle", int'(busy), 0);
  endtask

  task automatic check_cfg();
    chk("sel", int'(sel), m_sel);
    chk("block_reset", int'(block_reset), m_br);
    chk("block_hold", int'(block_hold), m_bh);
    chk("polarity", int'(polarity), m_pol);
    chk("reset_release_time", int'(reset_release_time), m_rr);
    chk("aout_reset_release_time", int'(aout_reset_release_time), m_arr);
    chk("measure_time", int'(measure_time), m_mt);
  endtask

  task automatic check_counts();
    chk("trig_count", int'(trig_count), m_trig);
    chk("missed_count", int'(missed_count), m_miss);
  endtask

  // Scoreboard monitor: every run pulse must match the next predicted cycle.
  always @(negedge clk) begin
    if (run_sequencer === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", cyc, -1);
      else chk("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  initial begin
    int e, t0, op, c, d;
    model_reset();
    m_sr = 1;
    repeat (3) @(posedge clk);
    #1;
    res_n = 1'b1;
    tick();

    // Reset values
    chk("rst_spi_d", int'(spi_d), 0);
    chk("rst_run", int'(run_sequencer), 0);
    chk("rst_busy", int'(busy), 0);
    check_counts();
    check_cfg();

    // Default timing: pulse 37 after edge, 100 busy cycles of holdoff
    e = cyc + SYNC_STAGES;
    trig(3);
    to_cyc(e + 137);
    chk("busy_end_holdoff", int'(busy), 1);
    wait_idle();
    chk("idle_cycle", cyc, e + 138);
    chk("trig_count_first", int'(trig_count), 1);

    // Command enable gate
    wr(16'h0005); chk("sel_locked", int'(sel), 0);
    wr(16'h9001); wr(16'h0005); chk("sel_open", int'(sel), 5);
    wr(16'h9000); wr(16'h0003); chk("sel_relocked", int'(sel), 5);
    check_cfg();

    // Zero delay / zero holdoff, then overlapping triggers
    wr(16'h9001); wr(16'h7000); wr(16'h8000);
    e = cyc + SYNC_STAGES;
    trig(1);
    to_cyc(e + 2); chk("busy_zero_hold", int'(busy), 1);
    to_cyc(e + 3); chk("idle_zero_hold", int'(busy), 0);
    wr(16'h8063);
    trig(3); repeat (5) tick(); trig(3);
    wait_idle();
    chk("missed_overlap", int'(missed_count), 1);
    check_counts();

    // Sequencer not ready
    wr(16'hC000);
    seq_ready = 1'b0; m_sr = 0;
    trig(3); wait_idle();
    chk("missed_not_ready", int'(missed_count), 1);
    chk("trig_not_ready", int'(trig_count), 0);
    seq_ready = 1'b1; m_sr = 1;

    // Disarmed, then software trigger re-arming
    wr(16'hA000);
    trig(2); repeat (3) tick();
    chk("disarmed_busy", int'(busy), 0);
    check_counts();
    wr(16'h7024);
    wr(16'hA005);
    wait_idle();
    check_counts();

    // Randomised phase
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        c = $urandom_range(0, 15);
        if (c == 12) c = 13;
        d = $urandom_range(0, 4095);
        if (c == 7 || c == 8) d = d & 12'hC3F;
        if (c == 9 && $urandom_range(0, 3) != 0) d = d | 1;
        wr({c[3:0], d[11:0]});
        check_cfg();
      end else if (op <= 7) begin
        trig($urandom_range(1, 4));
      end else if (op == 8) begin
        if (cyc >= m_idle_at) begin
          seq_ready = 1'($urandom_range(0, 1));
          m_sr = int'(seq_ready);
        end
        repeat ($urandom_range(1, 6)) tick();
      end else begin
        wait_idle();
        check_counts();
      end
    end
    wait_idle();
    check_counts();

    // Saturation
    seq_ready = 1'b1; m_sr = 1;
    wr(16'h9001); wr(16'h73FF); wr(16'h8000);
    wr(16'hA005);
    repeat (300) wr(16'hA005);
    wait_idle();
    chk("missed_saturated", int'(missed_count), CMAX);
    check_counts();
    seq_ready = 1'b0; m_sr = 0;
    wr(16'h7000);
    trig(3); wait_idle();
    chk("missed_stays_sat", int'(missed_count), CMAX);
    check_counts();

    // Clear coinciding with the FIRE-cycle increment
    seq_ready = 1'b1; m_sr = 1;
    wr(16'h7005);
    wait_idle();
    t0 = cyc;
    wr(16'hA005);
    to_cyc(t0 + 7);
    wr(16'hC000);
    wait_idle();
    chk("clear_wins_trig", int'(trig_count), 0);
    chk("clear_wins_missed", int'(missed_count), 0);

    // Readback selection
    seq_ready = 1'b0; m_sr = 0;
    trig(3); wait_idle();
    seq_ready = 1'b1; m_sr = 1;
    wr(16'hB001); tick(); chk("spi_d_missed", int'(spi_d), m_miss);
    wr(16'hB000); tick(); chk("spi_d_trig", int'(spi_d), m_trig);
    wr(16'hB002); tick(); chk("spi_d_status", int'(spi_d), m_armed * 2 + m_en);
    wr(16'hB003); tick(); chk("spi_d_other", int'(spi_d), 0);

    // Reset in mid-sequence: no pulse, everything back to defaults
    wr(16'h7010);
    trig(3);
    repeat (5) tick();
    chk("busy_before_reset", int'(busy), 1);
    res_n = 1'b0;
    exp_q.delete();
    model_reset();
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_run", int'(run_sequencer), 0);
    res_n = 1'b1;
    tick();
    check_cfg();
    check_counts();
    chk("reset_spi_d", int'(spi_d), 0);
    repeat (40) tick();
    chk("no_pulse_after_reset", int'(trig_count), 0);
    chk("pulses_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
